mem_arbiter: RTL

- Two-port round-robin arbiter sharing one synchronous single-port RAM (1-cycle registered read) between two bus masters.
- Port 0 is the 16-bit processor's load/store path; port 1 is a DMA/program-loader master.
- Serialises requests, registers the winning address, data and write strobe onto the memory bus, and returns read data with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous single-port RAM
// with a 1-cycle registered read.
//
// Port 0 is the processor load/store path; port 1 is a DMA/program-loader master.
// Requests are sampled only in IDLE. The winning request is captured onto the
// memory bus, and the winner gets a one-cycle gnt pulse. For a read, the winner
// also gets a one-cycle rvalid pulse two cycles after gnt.
//
// Ports:
//   Clock, Resetn          rising-edge clock, synchronous active-low reset
//   mN_req/we/addr/wdata   master N request (held until mN_gnt)
//   mN_gnt                 one-cycle pulse: request issued to memory
//   mN_rvalid, mN_rdata    one-cycle read-data valid pulse, per-port read data register
//   mem_addr/wdata/we      registered RAM bus
//   mem_rdata              RAM q, valid the cycle after the address is clocked in
//   busy                   high whenever the arbiter is not in IDLE
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StRwait, StRdone} state_e;

  state_e state_q, state_d;

  logic          prio_q, prio_d;   // port index that wins a tie
  logic          win_q, win_d;     // port served by the current transaction
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic any_req;
  logic pick;

  assign any_req = m0_req | m1_req;
  // On a tie the pointer decides; otherwise the only requester wins.
  assign pick    = (m0_req & m1_req) ? prio_q : m1_req;

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = we_q ? StIdle : StRwait;
      StRwait: state_d = StRdone;
      StRdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    mem_we    = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIssue: begin
        m0_gnt = ~win_q;
        m1_gnt = win_q;
        mem_we = we_q;
      end
      StRdone: begin
        m0_rvalid = ~win_q;
        m1_rvalid = win_q;
      end
      default: ;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  // Datapath next-state.
  always_comb begin
    prio_d      = prio_q;
    win_d       = win_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d       = pick;
          we_d        = pick ? m1_we    : m0_we;
          mem_addr_d  = pick ? m1_addr  : m0_addr;
          mem_wdata_d = pick ? m1_wdata : m0_wdata;
        end
      end
      StIssue: prio_d = ~win_q;
      StRwait: begin
        if (win_q) m1_rdata_d = mem_rdata;
        else       m0_rdata_d = mem_rdata;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      prio_q      <= 1'b0;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      prio_q      <= prio_d;
      win_q       <= win_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

endmodule
